// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the ID/EX register, the mult/div unit and the hazard unit.
// The master drives an operation; the slave returns HI/LO, busy and the stall request.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, stall_req, hi, lo);
  modport slave  (input start, op, a, b, output busy, stall_req, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept time; the RUN period only models latency.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      res_hi, res_hi_n;
  logic [31:0]      res_lo, res_lo_n;
  logic             commit, commit_n;
  logic             busy_q, busy_n;
  logic [31:0]      hi_q, hi_n;
  logic [31:0]      lo_q, lo_n;

  logic        op_signed;
  logic        is_md_op;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] dvd, dvs, dvs_safe, quo_mag, rem_mag, quo, rem;

  // Operand conditioning: sign/zero-extend for the multiplier, magnitudes for the divider
  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_md_op  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

  assign mul_a   = {{32{op_signed & bus.a[31]}}, bus.a};
  assign mul_b   = {{32{op_signed & bus.b[31]}}, bus.b};
  assign product = mul_a * mul_b;

  // Signed divide via unsigned magnitudes avoids the INT_MIN / -1 overflow case
  assign dvd      = (op_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign dvs      = (op_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
  assign dvs_safe = (bus.b == 32'd0) ? 32'd1 : dvs;
  assign quo_mag  = dvd / dvs_safe;
  assign rem_mag  = dvd % dvs_safe;
  assign quo      = (op_signed && (bus.a[31] ^ bus.b[31])) ? (32'd0 - quo_mag) : quo_mag;
  assign rem      = (op_signed && bus.a[31]) ? (32'd0 - rem_mag) : rem_mag;

  // Next-state and register-update logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    res_hi_n = res_hi;
    res_lo_n = res_lo;
    commit_n = commit;
    hi_n     = hi_q;
    lo_n     = lo_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              res_hi_n = product[63:32];
              res_lo_n = product[31:0];
              cnt_n    = CNT_W'(MULT_CYCLES);
              commit_n = 1'b1;
              state_n  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_n = rem;
              res_lo_n = quo;
              cnt_n    = CNT_W'(DIV_CYCLES);
              commit_n = (bus.b != 32'd0);
              state_n  = RUN;
            end
            OP_MTHI: hi_n = bus.a;
            OP_MTLO: lo_n = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (commit) begin
            hi_n = res_hi;
            lo_n = res_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      commit <= 1'b0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      res_hi <= res_hi_n;
      res_lo <= res_lo_n;
      commit <= commit_n;
      busy_q <= busy_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = busy_q | (bus.start & is_md_op);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// mid-run sequences and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int cycles_for(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return MULT_N;
      3'd3, 3'd4: return DIV_N;
      default:    return 0;
    endcase
  endfunction

  // Architectural result from plain 64-bit arithmetic
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h0,
                                         input logic [31:0] l0);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {h0, l0};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {h0, l0};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd5: return {a, l0};
      3'd6: return {h0, a};
      default: return {h0, l0};
    endcase
  endfunction

  // Issue one op in the current (idle) cycle and follow it to completion
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n, exp_n, stalls;
    logic held;
    exp_n = cycles_for(op);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    #1;
    chk($sformatf("%s_stall_accept", name), 32'(bus.stall_req), 32'(exp_n != 0));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.a = $urandom;
    bus.b = $urandom;
    #1;
    n = 0;
    stalls = 0;
    held = 1'b1;
    while (bus.busy && n < 40) begin
      if (bus.stall_req) stalls++;
      if (bus.hi !== hi_m || bus.lo !== lo_m) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("%s_busy_cycles", name), 32'(n), 32'(exp_n));
    chk($sformatf("%s_stall_cycles", name), 32'(stalls), 32'(exp_n));
    chk($sformatf("%s_old_value_held", name), 32'(held), 32'd1);
    chk($sformatf("%s_hi", name), bus.hi, eh);
    chk($sformatf("%s_lo", name), bus.lo, el);
    hi_m = eh;
    lo_m = el;
  endtask

  vec_t vecs[11];

  initial begin
    int n;
    logic [63:0] r;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    hi_m = '0;
    lo_m = '0;

    vecs[0]  = '{"mult_neg",   3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{"multu",      3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2]  = '{"div_neg",    3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu",       3'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4]  = '{"div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{"mthi",       3'd5, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000};
    vecs[6]  = '{"mtlo",       3'd6, 32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[7]  = '{"div_zero",   3'd3, 32'h0000_0064, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[8]  = '{"op_none",    3'd7, 32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[9]  = '{"b2b_multu",  3'd2, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C};
    vecs[10] = '{"b2b_divu",   3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_stall", 32'(bus.stall_req), 32'd0);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTHI and DIV issued while a MULT is in flight must be ignored
    bus.start = 1'b1;
    bus.op = 3'd1;
    bus.a = 32'h0000_1234;
    bus.b = 32'hFFFF_FFF0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    #1;
    n = 0;
    while (bus.busy && n < 40) begin
      bus.start = (n == 1 || n == 2);
      bus.op = (n == 1) ? 3'd5 : 3'd3;
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h0000_0003;
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    chk("conflict_busy_cycles", 32'(n), 32'(MULT_N));
    chk("conflict_hi", bus.hi, 32'hFFFF_FFFF);
    chk("conflict_lo", bus.lo, 32'hFFFE_DCC0);
    @(posedge clk);
    #1;
    chk("conflict_no_div_start", 32'(bus.busy), 32'd0);
    hi_m = 32'hFFFF_FFFF;
    lo_m = 32'hFFFE_DCC0;

    // Reset in busy cycle 3 aborts the MULT; nothing commits later
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.a = 32'h0000_0009;
    bus.b = 32'h0000_0009;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) n++;
    end
    chk("abort_no_commit", 32'(n), 32'd0);
    hi_m = '0;
    lo_m = '0;

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      r = ref_op(rop, ra, rb, hi_m, lo_m);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, r[63:32], r[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EX stage and is driven directly from the ID/EX pipeline register outputs: the start strobe, the operand values A and B, and the decoded operation. It produces HI/LO for the mfhi/mflo datapath, plus a busy indication for the hazard unit. The hazard unit stalls any multiply/divide-related instruction in ID while the unit is occupied.

## Interface
- MULT_CYCLES, 5, cycles from an accepted mult/multu to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from an accepted div/divu to HI/LO update (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  op valid for this cycle (ID/EX start bit)
- op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- a  in  32  rs operand
- b  in  32  rt operand
- busy  out  1  registered; high while an operation is in flight
- stall_req  out  1  combinational: busy | (start & op in 1..4)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Down-counter cnt (width sufficient for max(MULT_CYCLES, DIV_CYCLES)). Staging registers res_hi/res_lo.
- IDLE, start & op=1..4:
  - compute the 64-bit result from a and b at this edge into res_hi/res_lo
  - load cnt with MULT_CYCLES or DIV_CYCLES
  - go to RUN
- IDLE, start & op=5: hi<=a. start & op=6: lo<=a. Both update at this edge and the unit stays IDLE.
- RUN: cnt decrements each edge. On the edge where cnt reaches its final value (1→0): hi<=res_hi, lo<=res_lo, go to IDLE.
- While RUN, start is ignored for every op, including MTHI/MTLO. The hazard unit never issues in this state, and the bench checks that ignoring is what happens.
- MULT: signed 32×32→64; {hi,lo}=product.
- MULTU: unsigned 32×32→64.
- DIV: signed. lo=quotient truncated toward zero; hi=remainder, which carries the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU: unsigned; lo=quotient, hi=remainder.
- Divide by zero (b=0, DIV or DIVU):
  - the unit still goes busy for DIV_CYCLES
  - at completion hi/lo keep their prior values and are not written
- The multiply/divide is computed combinationally at accept time and latched. The RUN period only models latency.

## Timing
- Reset (synchronous): busy=0, hi=0, lo=0, cnt=0, res_hi=res_lo=0, state IDLE. Reset has priority over start.
- Reset during RUN: the operation is aborted, hi/lo become 0, and nothing is committed afterwards.
- Accept at edge k → busy=1 after edge k through edge k+N−1 → at edge k+N hi/lo are written and busy falls. The register result is visible on the cycle busy is 0. N=MULT_CYCLES or DIV_CYCLES.
- stall_req is high in the accept cycle itself (start & op 1..4) and for the N busy cycles that follow: N+1 cycles in total.
- MTHI/MTLO: latency 1 edge, busy never rises.
- Back-to-back: a new start in the first cycle with busy=0 is accepted. The unit has no dead cycle.
- hi/lo are plain register outputs. A read in the completion cycle sees the old value; the read in the next cycle sees the new value.

## Test plan
- Reset: drive reset 1 cycle, then leave inputs idle → busy=0, hi=0, lo=0, stall_req=0.
- MULT a=0xFFFFFFFE(−2) b=0x00000003, start at edge 0 → busy high for exactly 5 cycles, stall_req high 6 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA after edge 5.
  - Repeat as MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9(−7) b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7 b=2 → lo=3, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo update one edge each, busy stays 0.
  - Then DIV with b=0 → busy for 10 cycles, hi/lo unchanged.
- Mid-run conflicts:
  - Start MULT, then in busy cycle 2 pulse start with MTHI and with DIV → both ignored; final hi/lo equal the MULT result, busy length still 5.
  - Separately, assert reset in busy cycle 3 → busy=0, hi=lo=0, and no later commit.
- Back-to-back: MULTU 3×4 completes, then DIVU 100/7 starts in the first busy=0 cycle → lo=12 then lo=14, hi=2; no idle gap.
